// File: rtl/tl2chi_pkg.sv
// Shared TileLink-to-CHI definitions: opcodes, entry id type, burst states.
package tl2chi_pkg;

  localparam logic [2:0] TL_A_ACQUIREBLOCK = 3'd6;
  localparam logic [2:0] TL_A_ACQUIREPERM  = 3'd7;
  localparam logic [2:0] TL_C_RELEASE      = 3'd6;
  localparam logic [2:0] TL_C_RELEASEDATA  = 3'd7;

  // Widest entry index any configuration may use (up to 256 entries).
  localparam int TL2CHI_MAX_ENTRIES = 256;
  localparam int ENT_ID_W           = $clog2(TL2CHI_MAX_ENTRIES);

  typedef logic [ENT_ID_W-1:0] ent_id_t;

  typedef enum logic {
    BURST_IDLE,
    BURST_CBURST
  } burst_state_t;

  function automatic logic a_opcode_ok(input logic [2:0] op);
    return (op == TL_A_ACQUIREBLOCK) || (op == TL_A_ACQUIREPERM);
  endfunction

  function automatic logic c_opcode_ok(input logic [2:0] op);
    return (op == TL_C_RELEASE) || (op == TL_C_RELEASEDATA);
  endfunction

endpackage

// File: rtl/tl_alloc_pick.sv
// Lowest-index free-entry finder used by the request allocator.
module tl_alloc_pick
  import tl2chi_pkg::*;
#(
  parameter int NUM_ENTRIES = 4
) (
  input  logic [NUM_ENTRIES-1:0] free_vec,
  output logic                   found,
  output ent_id_t                idx
);

  // Scan top-down so the lowest free index is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        found = 1'b1;
        idx   = ent_id_t'(i);
      end
    end
  end

endmodule

// File: rtl/tl_req_alloc.sv
// Entry allocator: picks a free tracker entry for TileLink A/C requests,
// blocks same-line conflicts and steers ReleaseData beats to their owner.
module tl_req_alloc
  import tl2chi_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int ADDR_W      = 32,
  parameter int LINE_OFS    = 6,
  parameter int DATA_BEATS  = 2
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              a_valid,
  output logic                                              a_ready,
  input  logic [2:0]                                        a_opcode,
  input  logic [ADDR_W-1:0]                                 a_addr,
  input  logic                                              c_valid,
  output logic                                              c_ready,
  input  logic [2:0]                                        c_opcode,
  input  logic [ADDR_W-1:0]                                 c_addr,
  input  logic [NUM_ENTRIES-1:0]                            ent_req_ready,
  output logic [NUM_ENTRIES-1:0]                            ent_acquireperm_valid,
  output logic [NUM_ENTRIES-1:0]                            ent_acquireblock_valid,
  output logic [NUM_ENTRIES-1:0]                            ent_release_valid,
  output logic [NUM_ENTRIES-1:0]                            ent_releasedata_valid,
  output logic                                              alloc_valid,
  output logic [$clog2(NUM_ENTRIES)-1:0]                    alloc_id,
  output logic                                              alloc_is_c,
  output logic                                              cdata_valid,
  output logic [$clog2(NUM_ENTRIES)-1:0]                    cdata_id,
  output logic [((DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1)-1:0] cdata_beat,
  output logic                                              err_opcode
);

  localparam int ID_W   = $clog2(NUM_ENTRIES);
  localparam int BEAT_W = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;
  localparam int LINE_W = ADDR_W - LINE_OFS;

  logic [NUM_ENTRIES-1:0] busy_q, busy_d;
  logic [LINE_W-1:0]      line_q [NUM_ENTRIES];
  logic [LINE_W-1:0]      line_d [NUM_ENTRIES];
  burst_state_t           state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  ent_id_t                owner_q, owner_d;

  logic [LINE_W-1:0]      a_line, c_line;
  logic [NUM_ENTRIES-1:0] free_vec, a_hit, c_hit;
  logic                   free_found;
  ent_id_t                free_idx;
  logic [ID_W-1:0]        free_id;
  logic                   c_win, c_bad, a_win, a_bad;

  assign a_line  = a_addr[ADDR_W-1:LINE_OFS];
  assign c_line  = c_addr[ADDR_W-1:LINE_OFS];
  assign free_id = ID_W'(free_idx);

  // An entry is free only when idle and its tracker is ready; a retiring
  // entry is still busy this cycle, so it is neither free nor conflict-free.
  always_comb begin
    free_vec = '0;
    a_hit    = '0;
    c_hit    = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      free_vec[i] = !busy_q[i] && ent_req_ready[i];
      a_hit[i]    = busy_q[i] && (line_q[i] == a_line);
      c_hit[i]    = busy_q[i] && (line_q[i] == c_line);
    end
  end

  tl_alloc_pick #(
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_pick (
    .free_vec (free_vec),
    .found    (free_found),
    .idx      (free_idx)
  );

  // Arbitration, dispatch strobes and burst next-state; C beats A so releases drain.
  always_comb begin
    a_ready                = 1'b0;
    c_ready                = 1'b0;
    alloc_valid            = 1'b0;
    alloc_id               = '0;
    alloc_is_c             = 1'b0;
    cdata_valid            = 1'b0;
    cdata_id               = '0;
    cdata_beat             = '0;
    err_opcode             = 1'b0;
    ent_acquireperm_valid  = '0;
    ent_acquireblock_valid = '0;
    ent_release_valid      = '0;
    ent_releasedata_valid  = '0;
    c_win                  = 1'b0;
    c_bad                  = 1'b0;
    a_win                  = 1'b0;
    a_bad                  = 1'b0;
    state_d                = state_q;
    beat_d                 = beat_q;
    owner_d                = owner_q;
    if (!reset) begin
      if (state_q == BURST_CBURST) begin
        c_ready     = c_valid;
        cdata_valid = c_valid;
        cdata_id    = ID_W'(owner_q);
        cdata_beat  = beat_q;
        if (c_valid) begin
          if (beat_q == BEAT_W'(DATA_BEATS - 1)) begin
            state_d = BURST_IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end else begin
        c_bad = c_valid && !c_opcode_ok(c_opcode);
        c_win = c_valid && c_opcode_ok(c_opcode) && free_found && !(|c_hit);
        a_bad = !c_win && !c_bad && a_valid && !a_opcode_ok(a_opcode);
        a_win = !c_win && !c_bad && a_valid && a_opcode_ok(a_opcode) &&
                free_found && !(|a_hit);
        c_ready    = c_win || c_bad;
        a_ready    = a_win || a_bad;
        err_opcode = c_bad || a_bad;
        if (c_win) begin
          alloc_valid = 1'b1;
          alloc_id    = free_id;
          alloc_is_c  = 1'b1;
          if (c_opcode == TL_C_RELEASE) begin
            ent_release_valid[free_id] = 1'b1;
          end else begin
            ent_releasedata_valid[free_id] = 1'b1;
            cdata_valid = 1'b1;
            cdata_id    = free_id;
            if (DATA_BEATS > 1) begin
              state_d = BURST_CBURST;
              owner_d = free_idx;
              beat_d  = BEAT_W'(1);
            end
          end
        end else if (a_win) begin
          alloc_valid = 1'b1;
          alloc_id    = free_id;
          if (a_opcode == TL_A_ACQUIREBLOCK) begin
            ent_acquireblock_valid[free_id] = 1'b1;
          end else begin
            ent_acquireperm_valid[free_id] = 1'b1;
          end
        end
      end
    end
  end

  // Retire entries whose tracker signals done, then claim the dispatched entry.
  always_comb begin
    busy_d = busy_q & ~ent_req_ready;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      line_d[i] = line_q[i];
    end
    if (alloc_valid) begin
      busy_d[alloc_id] = 1'b1;
      line_d[alloc_id] = alloc_is_c ? c_line : a_line;
    end
  end

  // Burst FSM, beat counter, owner and busy bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BURST_IDLE;
      beat_q  <= '0;
      owner_q <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
    end
  end

  // Line addresses are only meaningful while busy, so they need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      line_q[i] <= line_d[i];
    end
  end

endmodule

// File: tb/tb_tl_req_alloc.sv
// Testbench for tl_req_alloc: directed scenarios plus a randomized run
// against a behavioural allocation model.
module tb_tl_req_alloc;
  import tl2chi_pkg::*;

  localparam int NE = 4;
  localparam int AW = 32;
  localparam int LO = 6;
  localparam int DB = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_valid, a_ready, c_valid, c_ready;
  logic [2:0]    a_opcode, c_opcode;
  logic [AW-1:0] a_addr, c_addr;
  logic [NE-1:0] ent_req_ready;
  logic [NE-1:0] ent_acquireperm_valid, ent_acquireblock_valid;
  logic [NE-1:0] ent_release_valid, ent_releasedata_valid;
  logic          alloc_valid, alloc_is_c, cdata_valid, err_opcode;
  logic [1:0]    alloc_id, cdata_id;
  logic [0:0]    cdata_beat;
  logic [15:0]   strobes;

  int n_checks = 0;
  int n_fail   = 0;

  assign strobes = {ent_acquireperm_valid, ent_acquireblock_valid,
                    ent_release_valid, ent_releasedata_valid};

  always #5 clk = ~clk;

  tl_req_alloc #(
    .NUM_ENTRIES (NE),
    .ADDR_W      (AW),
    .LINE_OFS    (LO),
    .DATA_BEATS  (DB)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .a_valid                (a_valid),
    .a_ready                (a_ready),
    .a_opcode               (a_opcode),
    .a_addr                 (a_addr),
    .c_valid                (c_valid),
    .c_ready                (c_ready),
    .c_opcode               (c_opcode),
    .c_addr                 (c_addr),
    .ent_req_ready          (ent_req_ready),
    .ent_acquireperm_valid  (ent_acquireperm_valid),
    .ent_acquireblock_valid (ent_acquireblock_valid),
    .ent_release_valid      (ent_release_valid),
    .ent_releasedata_valid  (ent_releasedata_valid),
    .alloc_valid            (alloc_valid),
    .alloc_id               (alloc_id),
    .alloc_is_c             (alloc_is_c),
    .cdata_valid            (cdata_valid),
    .cdata_id               (cdata_id),
    .cdata_beat             (cdata_beat),
    .err_opcode             (err_opcode)
  );

  task automatic idle_inputs();
    a_valid  = 1'b0;
    a_opcode = 3'd0;
    a_addr   = '0;
    c_valid  = 1'b0;
    c_opcode = 3'd0;
    c_addr   = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    ent_req_ready = '0;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({a_ready, c_ready, alloc_valid, alloc_is_c, cdata_valid, err_opcode} !== 6'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctl: got %b want 000000",
               {a_ready, c_ready, alloc_valid, alloc_is_c, cdata_valid, err_opcode});
    end
    n_checks++;
    if ({strobes, alloc_id, cdata_id, cdata_beat} !== 21'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: got %h want 0", {strobes, alloc_id, cdata_id, cdata_beat});
    end
    next_cycle();
  endtask

  task automatic test_fill();
    logic [3:0] busy = 4'b0000;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      ent_req_ready = ~busy;
      a_valid  = 1'b1;
      a_opcode = TL_A_ACQUIREBLOCK;
      a_addr   = 32'(k * 64);
      @(negedge clk);
      n_checks++;
      if ({alloc_valid, a_ready, alloc_is_c} !== 3'b110) begin
        n_fail++;
        $display("[TB] FAIL fill_hs%0d: got %b want 110", k, {alloc_valid, a_ready, alloc_is_c});
      end
      n_checks++;
      if (alloc_id !== 2'(k)) begin
        n_fail++;
        $display("[TB] FAIL fill_id%0d: got %0d want %0d", k, alloc_id, k);
      end
      n_checks++;
      if (strobes !== (16'd1 << (8 + k))) begin
        n_fail++;
        $display("[TB] FAIL fill_strobe%0d: got %h want %h", k, strobes, 16'd1 << (8 + k));
      end
      next_cycle();
      busy[k] = 1'b1;
    end
    a_addr        = 32'h100;
    ent_req_ready = ~busy;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      n_checks++;
      if ({a_ready, alloc_valid} !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL fill_stall%0d: got %b want 00", s, {a_ready, alloc_valid});
      end
      next_cycle();
    end
    ent_req_ready = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (a_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL fill_retire_cycle: got a_ready=%b want 0", a_ready);
    end
    next_cycle();
    busy[2]       = 1'b0;
    ent_req_ready = ~busy;
    @(negedge clk);
    n_checks++;
    if ({a_ready, alloc_valid, alloc_id, strobes} !== {2'b11, 2'd2, 16'h0400}) begin
      n_fail++;
      $display("[TB] FAIL fill_reuse: got rdy=%b id=%0d strobes=%h want 11/2/0400",
               {a_ready, alloc_valid}, alloc_id, strobes);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    do_reset();
    ent_req_ready = 4'b1111;
    a_valid  = 1'b1;
    a_opcode = TL_A_ACQUIREPERM;
    a_addr   = 32'h100;
    c_valid  = 1'b1;
    c_opcode = TL_C_RELEASE;
    c_addr   = 32'h200;
    @(negedge clk);
    n_checks++;
    if ({c_ready, a_ready, alloc_valid, alloc_is_c, alloc_id, strobes} !==
        {4'b1011, 2'd0, 16'h0010}) begin
      n_fail++;
      $display("[TB] FAIL same_c: got c=%b a=%b isc=%b id=%0d strobes=%h want 1/0/1/0/0010",
               c_ready, a_ready, alloc_is_c, alloc_id, strobes);
    end
    next_cycle();
    c_valid       = 1'b0;
    ent_req_ready = 4'b1110;
    @(negedge clk);
    n_checks++;
    if ({a_ready, alloc_valid, alloc_is_c, alloc_id, strobes} !== {3'b110, 2'd1, 16'h2000}) begin
      n_fail++;
      $display("[TB] FAIL same_a: got a=%b isc=%b id=%0d strobes=%h want 1/0/1/2000",
               a_ready, alloc_is_c, alloc_id, strobes);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_release_data();
    do_reset();
    ent_req_ready = 4'b1111;
    c_valid  = 1'b1;
    c_opcode = TL_C_RELEASEDATA;
    c_addr   = 32'h300;
    @(negedge clk);
    n_checks++;
    if ({c_ready, alloc_valid, alloc_id, strobes, cdata_valid, cdata_id, cdata_beat} !==
        {2'b11, 2'd0, 16'h0001, 1'b1, 2'd0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL rdata_beat0: got c=%b id=%0d strobes=%h cdv=%b cid=%0d beat=%0d",
               c_ready, alloc_id, strobes, cdata_valid, cdata_id, cdata_beat);
    end
    next_cycle();
    ent_req_ready = 4'b0000;
    a_valid  = 1'b1;
    a_opcode = TL_A_ACQUIREBLOCK;
    a_addr   = 32'h400;
    @(negedge clk);
    n_checks++;
    if ({c_ready, a_ready, alloc_valid, strobes} !== {3'b100, 16'h0000}) begin
      n_fail++;
      $display("[TB] FAIL rdata_beat1_hs: got c=%b a=%b av=%b strobes=%h want 1/0/0/0000",
               c_ready, a_ready, alloc_valid, strobes);
    end
    n_checks++;
    if ({cdata_valid, cdata_id, cdata_beat} !== {1'b1, 2'd0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL rdata_beat1_data: got v=%b id=%0d beat=%0d want 1/0/1",
               cdata_valid, cdata_id, cdata_beat);
    end
    next_cycle();
    c_valid       = 1'b0;
    ent_req_ready = 4'b1110;
    @(negedge clk);
    n_checks++;
    if ({a_ready, alloc_valid, alloc_id} !== {2'b11, 2'd1}) begin
      n_fail++;
      $display("[TB] FAIL rdata_after: got a=%b av=%b id=%0d want 1/1/1",
               a_ready, alloc_valid, alloc_id);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_conflict();
    do_reset();
    ent_req_ready = 4'b1111;
    a_valid  = 1'b1;
    a_opcode = TL_A_ACQUIREBLOCK;
    a_addr   = 32'h1000;
    next_cycle();
    a_addr        = 32'h1020;
    ent_req_ready = 4'b1110;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      n_checks++;
      if ({a_ready, alloc_valid} !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL conflict_stall%0d: got %b want 00", s, {a_ready, alloc_valid});
      end
      next_cycle();
    end
    ent_req_ready = 4'b1111;
    @(negedge clk);
    n_checks++;
    if (a_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL conflict_retire: got a_ready=%b want 0", a_ready);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({a_ready, alloc_valid, alloc_id} !== {2'b11, 2'd0}) begin
      n_fail++;
      $display("[TB] FAIL conflict_go: got a=%b av=%b id=%0d want 1/1/0",
               a_ready, alloc_valid, alloc_id);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_bad_opcode();
    do_reset();
    ent_req_ready = 4'b1111;
    a_valid  = 1'b1;
    a_opcode = 3'd4;
    a_addr   = 32'h500;
    @(negedge clk);
    n_checks++;
    if ({a_ready, err_opcode, alloc_valid, strobes} !== {3'b110, 16'h0000}) begin
      n_fail++;
      $display("[TB] FAIL badop_accept: got a=%b err=%b av=%b strobes=%h want 1/1/0/0000",
               a_ready, err_opcode, alloc_valid, strobes);
    end
    next_cycle();
    a_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_opcode !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL badop_pulse: got err=%b want 0", err_opcode);
    end
    next_cycle();
    a_valid  = 1'b1;
    a_opcode = TL_A_ACQUIREBLOCK;
    @(negedge clk);
    n_checks++;
    if ({alloc_valid, alloc_id} !== {1'b1, 2'd0}) begin
      n_fail++;
      $display("[TB] FAIL badop_noalloc: got av=%b id=%0d want 1/0", alloc_valid, alloc_id);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_reset_burst();
    do_reset();
    ent_req_ready = 4'b1111;
    c_valid  = 1'b1;
    c_opcode = TL_C_RELEASEDATA;
    c_addr   = 32'h300;
    @(negedge clk);
    n_checks++;
    if ({cdata_valid, alloc_valid} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL rstb_beat0: got cdv=%b av=%b want 1/1", cdata_valid, alloc_valid);
    end
    next_cycle();
    reset = 1'b1;
    idle_inputs();
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({a_ready, c_ready, alloc_valid, alloc_is_c, cdata_valid, err_opcode, strobes,
         alloc_id, cdata_id, cdata_beat} !== 27'd0) begin
      n_fail++;
      $display("[TB] FAIL rstb_outputs: got %h want 0",
               {a_ready, c_ready, alloc_valid, alloc_is_c, cdata_valid, err_opcode, strobes,
                alloc_id, cdata_id, cdata_beat});
    end
    next_cycle();
    a_valid  = 1'b1;
    a_opcode = TL_A_ACQUIREBLOCK;
    a_addr   = 32'h300;
    @(negedge clk);
    n_checks++;
    if ({a_ready, alloc_valid, alloc_id} !== {2'b11, 2'd0}) begin
      n_fail++;
      $display("[TB] FAIL rstb_busy_clear: got a=%b av=%b id=%0d want 1/1/0",
               a_ready, alloc_valid, alloc_id);
    end
    next_cycle();
    a_valid       = 1'b0;
    ent_req_ready = 4'b1110;
    c_valid  = 1'b1;
    c_opcode = TL_C_RELEASEDATA;
    c_addr   = 32'h340;
    @(negedge clk);
    n_checks++;
    if ({alloc_valid, alloc_id, cdata_valid, cdata_id, cdata_beat} !==
        {1'b1, 2'd1, 1'b1, 2'd1, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL rstb_new_req: got av=%b id=%0d cdv=%b cid=%0d beat=%0d want 1/1/1/1/0",
               alloc_valid, alloc_id, cdata_valid, cdata_id, cdata_beat);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  // Randomized traffic compared against a model of the allocation rules.
  task automatic test_random();
    bit          m_busy [NE];
    logic [25:0] m_line [NE];
    bit          m_burst = 1'b0;
    int          m_owner = 0;
    int          m_beat  = 0;
    do_reset();
    for (int i = 0; i < NE; i++) m_busy[i] = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      int          free;
      bit          a_sup, c_sup, a_conf, c_conf;
      bit          e_ar, e_cr, e_av, e_isc, e_cdv, e_err;
      int          e_id, e_cid, e_beat;
      logic [15:0] e_str;
      a_valid  = ($urandom_range(0, 2) != 0);
      a_opcode = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
      a_addr   = 32'h1000 + 32'($urandom_range(0, 5)) * 64 + 32'($urandom_range(0, 63));
      c_valid  = ($urandom_range(0, 2) == 0);
      c_opcode = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
      c_addr   = 32'h1000 + 32'($urandom_range(0, 5)) * 64 + 32'($urandom_range(0, 63));
      for (int i = 0; i < NE; i++) begin
        ent_req_ready[i] = m_busy[i] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      end
      free = -1;
      for (int i = NE - 1; i >= 0; i--) if (!m_busy[i] && ent_req_ready[i]) free = i;
      c_conf = 1'b0;
      a_conf = 1'b0;
      for (int i = 0; i < NE; i++) begin
        if (m_busy[i] && m_line[i] == c_addr[31:6]) c_conf = 1'b1;
        if (m_busy[i] && m_line[i] == a_addr[31:6]) a_conf = 1'b1;
      end
      c_sup = (c_opcode == 3'd6) || (c_opcode == 3'd7);
      a_sup = (a_opcode == 3'd6) || (a_opcode == 3'd7);
      {e_ar, e_cr, e_av, e_isc, e_cdv, e_err} = 6'd0;
      e_id = 0; e_cid = 0; e_beat = 0; e_str = 16'd0;
      if (m_burst) begin
        e_cr = c_valid; e_cdv = c_valid; e_cid = m_owner; e_beat = m_beat;
      end else if (c_valid && !c_sup) begin
        e_cr = 1'b1; e_err = 1'b1;
      end else if (c_valid && free >= 0 && !c_conf) begin
        e_cr = 1'b1; e_av = 1'b1; e_isc = 1'b1; e_id = free;
        if (c_opcode == 3'd6) e_str = 16'd1 << (4 + free);
        else begin
          e_str = 16'd1 << free; e_cdv = 1'b1; e_cid = free; e_beat = 0;
        end
      end else if (a_valid && !a_sup) begin
        e_ar = 1'b1; e_err = 1'b1;
      end else if (a_valid && free >= 0 && !a_conf) begin
        e_ar = 1'b1; e_av = 1'b1; e_id = free;
        e_str = (a_opcode == 3'd6) ? (16'd1 << (8 + free)) : (16'd1 << (12 + free));
      end
      @(negedge clk);
      n_checks++;
      if ({a_ready, c_ready, alloc_valid, cdata_valid, err_opcode} !== {e_ar, e_cr, e_av, e_cdv, e_err}) begin
        n_fail++;
        $display("[TB] FAIL rand_ctl cyc%0d: got a/c/av/cdv/err=%b want %b", cyc,
                 {a_ready, c_ready, alloc_valid, cdata_valid, err_opcode},
                 {e_ar, e_cr, e_av, e_cdv, e_err});
      end
      n_checks++;
      if (strobes !== e_str) begin
        n_fail++;
        $display("[TB] FAIL rand_strobe cyc%0d: got %h want %h", cyc, strobes, e_str);
      end
      if (e_av) begin
        n_checks++;
        if ({alloc_id, alloc_is_c} !== {2'(e_id), e_isc}) begin
          n_fail++;
          $display("[TB] FAIL rand_alloc cyc%0d: got id=%0d isc=%b want %0d/%b", cyc,
                   alloc_id, alloc_is_c, e_id, e_isc);
        end
      end
      if (e_cdv) begin
        n_checks++;
        if ({cdata_id, cdata_beat} !== {2'(e_cid), 1'(e_beat)}) begin
          n_fail++;
          $display("[TB] FAIL rand_cdata cyc%0d: got id=%0d beat=%0d want %0d/%0d", cyc,
                   cdata_id, cdata_beat, e_cid, e_beat);
        end
      end
      for (int i = 0; i < NE; i++) if (m_busy[i] && ent_req_ready[i]) m_busy[i] = 1'b0;
      if (e_av) begin
        m_busy[e_id] = 1'b1;
        m_line[e_id] = e_isc ? c_addr[31:6] : a_addr[31:6];
      end
      if (m_burst) begin
        if (c_valid) begin
          m_beat++;
          if (m_beat == DB) m_burst = 1'b0;
        end
      end else if (e_av && e_isc && c_opcode == 3'd7 && DB > 1) begin
        m_burst = 1'b1; m_owner = e_id; m_beat = 1;
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    ent_req_ready = '0;
    test_reset();
    test_fill();
    test_same_cycle();
    test_release_data();
    test_conflict();
    test_bad_opcode();
    test_reset_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_req_alloc.md
# tl_req_alloc

Entry allocator ahead of the per-entry TileLink-to-CHI state trackers. It accepts TileLink A-channel AcquireBlock/AcquirePerm and C-channel Release/ReleaseData requests. For each one it picks a free entry, blocks same-cache-line conflicts, and raises exactly one request-valid strobe into the chosen entry. It also reports the entry index so the payload datapath can capture address, source and data.

## Interface
Parameters:
- NUM_ENTRIES, 4, number of downstream entries (power of two, ≥2)
- ADDR_W, 32, TileLink address width
- LINE_OFS, 6, byte-offset bits; line address = addr[ADDR_W-1:LINE_OFS]
- DATA_BEATS, 2, C-channel beats per ReleaseData

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- a_valid  in  1  A-channel request valid
- a_ready  out  1  A-channel accept
- a_opcode  in  3  6=AcquireBlock, 7=AcquirePerm
- a_addr  in  ADDR_W  request address
- c_valid  in  1  C-channel beat valid
- c_ready  out  1  C-channel accept
- c_opcode  in  3  6=Release, 7=ReleaseData
- c_addr  in  ADDR_W  request address
- ent_req_ready  in  NUM_ENTRIES  per-entry request-ready from each state tracker
- ent_acquireperm_valid  out  NUM_ENTRIES  one-hot dispatch strobe
- ent_acquireblock_valid  out  NUM_ENTRIES  one-hot dispatch strobe
- ent_release_valid  out  NUM_ENTRIES  one-hot dispatch strobe
- ent_releasedata_valid  out  NUM_ENTRIES  one-hot dispatch strobe
- alloc_valid  out  1  a request is being dispatched this cycle
- alloc_id  out  $clog2(NUM_ENTRIES)  index of the target entry
- alloc_is_c  out  1  dispatched request came from C
- cdata_valid  out  1  a ReleaseData beat is being accepted
- cdata_id  out  $clog2(NUM_ENTRIES)  entry owning that beat
- cdata_beat  out  $clog2(DATA_BEATS)  beat index
- err_opcode  out  1  one-cycle pulse: an unsupported opcode was accepted and dropped

## Operation
- State per entry: busy bit and line-address register.
- A single burst FSM (IDLE, CBURST) with a beat counter and an owner-id register.
- Free entry: the lowest index i with !busy[i] and ent_req_ready[i].
- Conflict: the incoming line address equals the stored line of any busy entry.
- IDLE arbitration (C has strict priority so releases always drain):
  - C wins when c_valid, a free entry exists and there is no conflict.
  - A wins only when C does not win, a_valid, a free entry exists and there is no A conflict.
- Dispatch (same cycle):
  - Assert the matching ent_*_valid[free] strobe, alloc_valid and alloc_id, plus the accepting ready.
  - At the next edge, set busy[free] and capture the line address.
- Release is single-beat.
- ReleaseData:
  - Its first beat dispatches the request and also produces cdata_valid with cdata_beat=0.
  - If DATA_BEATS>1, the FSM goes to CBURST with owner=free and counter=1.
- CBURST:
  - c_ready = c_valid, regardless of free entries or conflicts.
  - Each beat drives cdata_valid, cdata_id=owner and cdata_beat=counter, then increments the counter.
  - After beat DATA_BEATS-1 the FSM returns to IDLE.
  - a_ready=0 throughout CBURST.
- Unsupported opcode (A not 6/7, C not 6/7, in IDLE): accept without dispatch and pulse err_opcode.
- Entry retirement: busy[i] clears at the edge where busy[i] and ent_req_ready[i] are both high (the entry's all-done cycle). Entry i is not considered free during that cycle.
- Reset clears all busy bits, the FSM (to IDLE) and the counter. All outputs are 0 out of reset, including a_ready and c_ready.

## Timing
- Dispatch latency is 0 cycles: the strobe is combinational with the accepting handshake. A freed entry becomes allocatable 1 cycle after its retirement edge.
- Throughput: one new request per cycle while free entries exist.
- a_ready and c_ready never depend on their own channel's ready; they may depend on its valid, opcode and address.
- When A and C request the same free entry in the same cycle, only C is accepted. A retries the next cycle with the next free entry.
- When all entries are busy, a_ready=c_ready=0 in IDLE. A CBURST already in progress still completes.
- If reset is asserted mid-burst, the FSM returns to IDLE and the remaining beats are treated as new requests.
- A release and an acquire to the same line: the release wins and the acquire stalls until the release's entry retires.

## Structure
- Shared package tl2chi_pkg holds:
  - TileLink opcode constants: TL_A_ACQUIREBLOCK=6, TL_A_ACQUIREPERM=7, TL_C_RELEASE=6, TL_C_RELEASEDATA=7.
  - An entry-id typedef.
- One natural sub-module: tl_alloc_pick, the lowest-index free-entry finder returning a found flag and an index. Everything else stays flat.

## Test plan
- Four AcquireBlocks to lines 0x000, 0x040, 0x080, 0x0C0 on consecutive cycles.
  - They dispatch to ids 0, 1, 2, 3 and alloc_valid is high for 4 cycles.
  - The fifth request stalls until entry 2's ent_req_ready pulse, then goes to id 2 one cycle later.
- Same-cycle AcquirePerm(0x100) and Release(0x200) with all entries free: Release goes to id 0, and AcquirePerm goes to id 1 the next cycle.
- ReleaseData(0x300) with DATA_BEATS=2:
  - Beat 0 is dispatched with cdata_beat=0.
  - Beat 1 arrives with entries full and is still accepted, with cdata_id=0 and cdata_beat=1.
  - a_ready stays 0 during the burst.
- Busy entry holding line 0x1000 and a new AcquireBlock to 0x1020: stalls (a_ready=0) until retirement, then dispatches.
- a_opcode=4: accepted, err_opcode pulses once and no ent_* strobe fires.
- Reset asserted in CBURST after beat 0: next cycle busy=0, the FSM is IDLE and all outputs are 0.
